// File: rtl/adsr_envelope.sv
// adsr_envelope: per-sample ADSR amplitude envelope followed by a two-stage gain pipeline.
// The envelope level scales the oscillator sample; out trails the level that produced it by two edges.
module adsr_envelope #(
    parameter int BITSIZE = 24,
    parameter int ENVSIZE = 16
) (
    input  logic                      lrclk,
    input  logic                      resetn,
    input  logic                      gate,
    input  logic [ENVSIZE-1:0]        attack,
    input  logic [ENVSIZE-1:0]        decay,
    input  logic [ENVSIZE-1:0]        sustain,
    input  logic [ENVSIZE-1:0]        release_rate,
    input  logic signed [BITSIZE-1:0] in,
    output logic signed [BITSIZE-1:0] out,
    output logic [ENVSIZE-1:0]        level,
    output logic                      active
);
    localparam int PW = BITSIZE + ENVSIZE + 1;
    localparam logic [ENVSIZE-1:0] MAX = '1;

    typedef enum logic [2:0] {IDLE, ATTACK, DECAY, SUSTAIN, RELEASE} state_t;

    state_t state, state_nx;
    logic [ENVSIZE-1:0] level_nx;
    logic [ENVSIZE:0] att_sum, dec_floor;
    logic signed [PW-1:0] in_x, lvl_x, p;
    logic p_unused;

    // one extra bit so neither comparison can wrap
    assign att_sum   = {1'b0, level} + {1'b0, attack};
    assign dec_floor = {1'b0, sustain} + {1'b0, decay};

    always_comb begin
        state_nx = state;
        level_nx = level;
        case (state)
            IDLE:    if (gate) state_nx = ATTACK;
            ATTACK:
                if (!gate) state_nx = RELEASE;
                else if (attack == '0 || att_sum >= {1'b0, MAX}) begin
                    level_nx = MAX;
                    state_nx = DECAY;
                end else level_nx = att_sum[ENVSIZE-1:0];
            DECAY:
                if (!gate) state_nx = RELEASE;
                else if (decay == '0 || {1'b0, level} <= dec_floor) begin
                    level_nx = sustain;
                    state_nx = SUSTAIN;
                end else level_nx = level - decay;
            SUSTAIN:
                if (!gate) state_nx = RELEASE;
                else level_nx = sustain;
            RELEASE:
                if (gate) state_nx = ATTACK;
                else if (release_rate == '0 || level <= release_rate) begin
                    level_nx = '0;
                    state_nx = IDLE;
                end else level_nx = level - release_rate;
            default: begin
                state_nx = IDLE;
                level_nx = '0;
            end
        endcase
    end

    always_ff @(posedge lrclk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            level  <= '0;
            active <= 1'b0;
        end else begin
            state  <= state_nx;
            level  <= level_nx;
            active <= state_nx != IDLE;
        end
    end

    // level is zero-extended so it multiplies as a non-negative gain below unity
    assign in_x     = PW'(in);
    assign lvl_x    = {{(BITSIZE + 1){1'b0}}, level};
    assign p_unused = ^{p[PW-1], p[ENVSIZE-1:0]};

    always_ff @(posedge lrclk or negedge resetn) begin
        if (!resetn) begin
            p   <= '0;
            out <= '0;
        end else begin
            p   <= in_x * lvl_x;
            out <= p[BITSIZE+ENVSIZE-1:ENVSIZE];
        end
    end
endmodule

// File: tb/tb_adsr_envelope.sv
// tb_adsr_envelope: directed-step bench for adsr_envelope with hand-computed expectations.
module tb_adsr_envelope;
    logic        lrclk = 1'b0;
    logic        resetn = 1'b0;
    logic        gate = 1'b0;
    logic [15:0] attack = '0, decay = '0, sustain = '0, rel = '0;
    logic [23:0] in = '0;
    logic [23:0] out;
    logic [15:0] level;
    logic        active;
    int tests = 0;
    int failed = 0;

    adsr_envelope #(.BITSIZE(24), .ENVSIZE(16)) dut (
        .lrclk(lrclk), .resetn(resetn), .gate(gate), .attack(attack), .decay(decay),
        .sustain(sustain), .release_rate(rel), .in(in), .out(out), .level(level), .active(active)
    );

    always #5 lrclk = ~lrclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge lrclk);
        #1;
    endtask

    initial begin
        // reset state
        step();
        chk("rst_level", level, 0);
        chk("rst_out", out, 0);
        chk("rst_active", active, 0);

        // reset mid-attack
        resetn = 1; gate = 1; attack = 16'h1000; decay = 16'h0100; sustain = 16'h8000;
        rel = 16'h1000; in = 24'h400000;
        repeat (5) step();
        chk("pre_rst_level", level, 16'h4000);
        chk("pre_rst_active", active, 1);
        #2 resetn = 0;
        #1;
        chk("async_rst_level", level, 0);
        chk("async_rst_out", out, 0);
        chk("async_rst_active", active, 0);
        step();
        resetn = 1;

        // attack ramp restarts from 0
        step();
        chk("restart_level", level, 0);
        chk("restart_active", active, 1);
        for (int k = 1; k <= 15; k++) begin
            step();
            chk("ramp_level", level, k * 32'h1000);
            if (k >= 2) chk("ramp_out", out, (k - 2) * 32'h40000);
        end
        step();
        chk("attack_top", level, 16'hFFFF);
        chk("attack_top_out", out, 24'h380000);

        // decay to sustain 0x8000
        for (int j = 1; j <= 127; j++) begin
            step();
            chk("decay_level", level, 32'hFFFF - j * 32'h100);
        end
        step();
        chk("decay_land", level, 16'h8000);
        step();
        step();
        chk("sustain_hold", level, 16'h8000);
        chk("sustain_out", out, 24'h200000);
        sustain = 16'h6000;
        step();
        chk("sustain_live", level, 16'h6000);

        // instantaneous release
        gate = 0; rel = 0;
        step();
        chk("rel0_gate_edge", level, 16'h6000);
        chk("rel0_gate_active", active, 1);
        step();
        chk("rel0_level", level, 0);
        chk("rel0_active", active, 0);

        // release mid-attack
        rel = 16'h1000; gate = 1;
        repeat (4) step();
        chk("rma_level", level, 16'h3000);
        gate = 0;
        step();
        chk("rma_gate_edge", level, 16'h3000);
        step();
        chk("rma_r1", level, 16'h2000);
        step();
        chk("rma_r2", level, 16'h1000);
        chk("rma_r2_active", active, 1);
        step();
        chk("rma_zero", level, 0);
        chk("rma_zero_active", active, 0);
        step();
        chk("rma_out_tail", out, 24'h040000);
        step();
        chk("rma_out_zero", out, 0);

        // zero rates
        attack = 0; decay = 0; rel = 0; sustain = 16'h4000; gate = 1;
        step();
        chk("zr_idle_edge", level, 0);
        step();
        chk("zr_attack", level, 16'hFFFF);
        step();
        chk("zr_decay", level, 16'h4000);
        step();
        chk("zr_hold", level, 16'h4000);
        gate = 0;
        step();
        chk("zr_gate_edge", level, 16'h4000);
        step();
        chk("zr_release", level, 0);
        chk("zr_active", active, 0);

        // signed path
        sustain = 16'h8000; gate = 1;
        repeat (3) step();
        chk("sg_level", level, 16'h8000);
        in = 24'hC00000;
        step();
        step();
        chk("sg_neg_half", out, 24'hE00000);
        sustain = 16'hFFFF;
        step();
        chk("sg_level_max", level, 16'hFFFF);
        in = 24'h800000;
        step();
        step();
        chk("sg_most_neg", out, 24'h800080);

        // sustain = MAX exits decay on first edge
        gate = 0;
        repeat (2) step();
        chk("smax_idle", active, 0);
        decay = 16'h0100; gate = 1;
        repeat (3) step();
        chk("smax_level", level, 16'hFFFF);
        sustain = 16'h1000;
        step();
        chk("smax_in_sustain", level, 16'h1000);

        // sustain = 0 holds active
        sustain = 0;
        step();
        step();
        chk("s0_level", level, 0);
        chk("s0_active", active, 1);

        // retrigger during release
        sustain = 16'h3000;
        step();
        gate = 0; rel = 16'h1000;
        step();
        chk("rt_gate_edge", level, 16'h3000);
        step();
        chk("rt_release", level, 16'h2000);
        gate = 1; attack = 16'h1000;
        step();
        chk("rt_attack_edge", level, 16'h2000);
        step();
        chk("rt_attack_next", level, 16'h3000);

        // gate toggling every edge
        gate = 0;
        step();
        chk("tg_0", level, 16'h3000);
        gate = 1;
        step();
        chk("tg_1", level, 16'h3000);
        gate = 0;
        step();
        chk("tg_2", level, 16'h3000);
        chk("tg_active", active, 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
